// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 control unit:
// FSM state codes, opcode patterns and ALU function codes.
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b101_1010_0;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASSB = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    function automatic logic is_cbz(input logic [10:0] op);
        return op[10:3] == OP_CBZ;
    endfunction

    function automatic logic is_rtype(input logic [10:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_ORR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags in,
// enables and mux selects out.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);

    logic [10:0]      op;
    logic             zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_en;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg2loc;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_control;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, zero, mem_ready,
        output ir_write, pc_en, reg_write,
        output mem_read, mem_write, mem_to_reg,
        output reg2loc, alu_src_a, alu_src_b,
        output alu_control, illegal, retired
    );

    modport slave (
        output op, zero, mem_ready,
        input  ir_write, pc_en, reg_write,
        input  mem_read, mem_write, mem_to_reg,
        input  reg2loc, alu_src_a, alu_src_b,
        input  alu_control, illegal, retired
    );

endinterface

// File: rtl/aludec.sv
// Maps alu_op plus the R-type opcode to the ALU function code.
module aludec
    import ctrl_pkg::*;
(
    input  logic [10:0] op,
    input  logic [1:0]  alu_op,
    output logic [3:0]  alu_control
);

    logic [3:0] funct_ctl;

    always_comb begin
        funct_ctl = ALU_ADD;
        unique case (1'b1)
            (op == OP_SUB): funct_ctl = ALU_SUB;
            (op == OP_AND): funct_ctl = ALU_AND;
            (op == OP_ORR): funct_ctl = ALU_ORR;
            default:        funct_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_PASSB: alu_control = ALU_PASSB;
            ALUOP_FUNCT: alu_control = funct_ctl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM with retired-instruction counter.
// Outputs are a Moore decode of state; pc_en/ir_write follow handshakes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       alu_op;
    logic [3:0]       alu_ctl;
    logic             op_mem, op_cbz, op_r, op_legal;
    logic             retire;

    logic             ir_write, pc_en, reg_write;
    logic             mem_read, mem_write, mem_to_reg;
    logic             reg2loc, alu_src_a, illegal;
    logic [1:0]       alu_src_b;

    assign op_mem   = (bus.op == OP_LDUR) || (bus.op == OP_STUR);
    assign op_cbz   = is_cbz(bus.op);
    assign op_r     = is_rtype(bus.op);
    assign op_legal = op_mem || op_cbz || op_r;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    op_mem:  state_d = S_MEMADR;
                    op_cbz:  state_d = S_BRANCH;
                    op_r:    state_d = S_EXEC_R;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:
                state_d = (bus.op == OP_LDUR) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                reg2loc   = op_cbz;
                illegal   = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: mem_read = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                reg2loc   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                reg2loc   = 1'b1;
                alu_op    = ALUOP_PASSB;
                pc_en     = bus.zero;
            end
            default: ;
        endcase
    end

    aludec u_aludec (
        .op          (bus.op),
        .alu_op      (alu_op),
        .alu_control (alu_ctl)
    );

    assign retire = (state_q == S_MEMWB) ||
                    (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEMWRITE) && bus.mem_ready);

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Handshake-driven strobes must stay low while reset is held.
    assign bus.ir_write    = ir_write & ~reset;
    assign bus.pc_en       = pc_en & ~reset;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg2loc     = reg2loc;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_ctl;
    assign bus.illegal     = illegal;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (CNT_W=4).
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    // ctl = {ir,pc,rw,mr,mw,m2r,r2l,asa,asb[1:0],alu[3:0],ill}
    localparam logic [14:0] C_F1  = 15'b1_1_0_1_0_0_0_0_01_0010_0;
    localparam logic [14:0] C_F0  = 15'b0_0_0_1_0_0_0_0_01_0010_0;
    localparam logic [14:0] C_DEC = 15'b0_0_0_0_0_0_0_0_10_0010_0;
    localparam logic [14:0] C_CBZ = 15'b0_0_0_0_0_0_1_0_10_0010_0;
    localparam logic [14:0] C_ILL = 15'b0_0_0_0_0_0_0_0_10_0010_1;
    localparam logic [14:0] C_MA  = 15'b0_0_0_0_0_0_0_1_10_0010_0;
    localparam logic [14:0] C_MR  = 15'b0_0_0_1_0_0_0_0_00_0010_0;
    localparam logic [14:0] C_MWB = 15'b0_0_1_0_0_1_0_0_00_0010_0;
    localparam logic [14:0] C_MW  = 15'b0_0_0_0_1_0_1_0_00_0010_0;
    localparam logic [14:0] C_AWB = 15'b0_0_1_0_0_0_0_0_00_0010_0;
    localparam logic [14:0] C_BR1 = 15'b0_1_0_0_0_0_1_1_00_0111_0;
    localparam logic [14:0] C_BR0 = 15'b0_0_0_0_0_0_1_1_00_0111_0;
    localparam logic [14:0] C_RST = 15'b0_0_0_1_0_0_0_0_01_0010_0;

    localparam logic [10:0] T_ADD = 11'b100_0101_1000;
    localparam logic [10:0] T_SUB = 11'b110_0101_1000;
    localparam logic [10:0] T_AND = 11'b100_0101_0000;
    localparam logic [10:0] T_ORR = 11'b101_0101_0000;
    localparam logic [10:0] T_LD  = 11'b111_1100_0010;
    localparam logic [10:0] T_ST  = 11'b111_1100_0000;
    localparam logic [10:0] T_CBZ = 11'b101_1010_0101;
    localparam logic [10:0] T_BAD = 11'b000_0000_0000;

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic        r;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [3:0]  ret;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    vec_t vq[$];

    multicycle_ctrl_if #(.CNT_W(4)) bus();

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [10:0] op,
                               input logic z, input logic r,
                               input logic [3:0] st,
                               input logic [14:0] ctl,
                               input logic [3:0] ret);
        vec_t x;
        x.op = op; x.z = z; x.r = r;
        x.st = st; x.ctl = ctl; x.ret = ret;
        return x;
    endfunction

    function automatic logic [14:0] ex(input logic [3:0] a);
        return {10'b0_0_0_0_0_0_0_1_00, a, 1'b0};
    endfunction

    function automatic logic [14:0] ctl_now();
        return {bus.ir_write, bus.pc_en, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.reg2loc, bus.alu_src_a, bus.alu_src_b,
                bus.alu_control, bus.illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic check_now(input string tag, input logic [3:0] st,
                             input logic [14:0] c,
                             input logic [3:0] rt);
        int nw;
        nw = int'(bus.reg_write) + int'(bus.mem_write) +
             int'(bus.ir_write);
        chk({tag, ".state"}, 32'(dut.state_q), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl_now()), 32'(c));
        chk({tag, ".retired"}, 32'(bus.retired), 32'(rt));
        chk({tag, ".wr_excl"}, 32'(nw > 1), 32'(0));
    endtask

    task automatic step(input string tag, input vec_t x);
        bus.op = x.op;
        bus.zero = x.z;
        bus.mem_ready = x.r;
        #2;
        check_now(tag, x.st, x.ctl, x.ret);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.op = T_BAD;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        vq.push_back(v(T_ADD, 0, 1, S_FETCH,  C_F1,       0));
        vq.push_back(v(T_ADD, 0, 1, S_DECODE, C_DEC,      0));
        vq.push_back(v(T_ADD, 0, 1, S_EXEC_R, ex(4'b0010), 0));
        vq.push_back(v(T_ADD, 0, 1, S_ALUWB,  C_AWB,      0));
        vq.push_back(v(T_SUB, 0, 1, S_FETCH,  C_F1,       1));
        vq.push_back(v(T_SUB, 0, 1, S_DECODE, C_DEC,      1));
        vq.push_back(v(T_SUB, 0, 1, S_EXEC_R, ex(4'b0110), 1));
        vq.push_back(v(T_SUB, 0, 1, S_ALUWB,  C_AWB,      1));
        vq.push_back(v(T_AND, 1, 1, S_FETCH,  C_F1,       2));
        vq.push_back(v(T_AND, 1, 1, S_DECODE, C_DEC,      2));
        vq.push_back(v(T_AND, 1, 1, S_EXEC_R, ex(4'b0000), 2));
        vq.push_back(v(T_AND, 1, 1, S_ALUWB,  C_AWB,      2));
        vq.push_back(v(T_ORR, 0, 1, S_FETCH,  C_F1,       3));
        vq.push_back(v(T_ORR, 0, 1, S_DECODE, C_DEC,      3));
        vq.push_back(v(T_ORR, 0, 1, S_EXEC_R, ex(4'b0001), 3));
        vq.push_back(v(T_ORR, 0, 1, S_ALUWB,  C_AWB,      3));
        vq.push_back(v(T_ST,  0, 1, S_FETCH,  C_F1,       4));
        vq.push_back(v(T_ST,  0, 1, S_DECODE, C_DEC,      4));
        vq.push_back(v(T_ST,  0, 1, S_MEMADR, C_MA,       4));
        vq.push_back(v(T_ST,  0, 1, S_MEMWRITE, C_MW,     4));
        vq.push_back(v(T_CBZ, 1, 1, S_FETCH,  C_F1,       5));
        vq.push_back(v(T_CBZ, 1, 1, S_DECODE, C_CBZ,      5));
        vq.push_back(v(T_CBZ, 1, 1, S_BRANCH, C_BR1,      5));
        vq.push_back(v(T_CBZ, 0, 1, S_FETCH,  C_F1,       6));
        vq.push_back(v(T_CBZ, 0, 1, S_DECODE, C_CBZ,      6));
        vq.push_back(v(T_CBZ, 0, 1, S_BRANCH, C_BR0,      6));
        vq.push_back(v(T_BAD, 0, 1, S_FETCH,  C_F1,       7));
        vq.push_back(v(T_BAD, 0, 1, S_DECODE, C_ILL,      7));
        vq.push_back(v(T_BAD, 0, 0, S_FETCH,  C_F0,       7));
        vq.push_back(v(T_LD,  1, 0, S_FETCH,  C_F0,       7));

        #12;
        check_now("reset", S_FETCH, C_RST, 0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++)
            step($sformatf("vec%0d", i), vq[i]);

        // Load with three wait cycles in MEMREAD: 8 cycles total.
        step("ld.f",  v(T_LD, 0, 1, S_FETCH,   C_F1,  7));
        step("ld.d",  v(T_LD, 0, 1, S_DECODE,  C_DEC, 7));
        step("ld.a",  v(T_LD, 0, 1, S_MEMADR,  C_MA,  7));
        step("ld.w0", v(T_LD, 0, 0, S_MEMREAD, C_MR,  7));
        step("ld.w1", v(T_BAD, 0, 0, S_MEMREAD, C_MR, 7));
        step("ld.w2", v(T_LD, 0, 0, S_MEMREAD, C_MR,  7));
        step("ld.r",  v(T_LD, 0, 1, S_MEMREAD, C_MR,  7));
        step("ld.wb", v(T_LD, 0, 1, S_MEMWB,   C_MWB, 7));

        // Store stalled in MEMWRITE, then reset mid-wait.
        step("st.f", v(T_ST, 0, 1, S_FETCH,  C_F1,  8));
        step("st.d", v(T_ST, 0, 1, S_DECODE, C_DEC, 8));
        step("st.a", v(T_ST, 0, 1, S_MEMADR, C_MA,  8));
        bus.mem_ready = 1'b0;
        #2;
        check_now("st.wait", S_MEMWRITE, C_MW, 8);
        reset = 1'b1;
        #1;
        check_now("st.rst", S_FETCH, C_RST, 0);
        bus.mem_ready = 1'b1;
        #1;
        check_now("rst.rdy", S_FETCH, C_RST, 0);
        @(posedge clk);
        #1;
        check_now("rst.hold", S_FETCH, C_RST, 0);
        reset = 1'b0;

        // 16 SUBs wrap the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) begin
            step("sub.f", v(T_SUB, 0, 1, S_FETCH,  C_F1,  4'(i)));
            step("sub.d", v(T_SUB, 0, 1, S_DECODE, C_DEC, 4'(i)));
            step("sub.x", v(T_SUB, 0, 1, S_EXEC_R,
                            ex(4'b0110), 4'(i)));
            step("sub.w", v(T_SUB, 0, 1, S_ALUWB,  C_AWB, 4'(i)));
        end
        step("wrap", v(T_SUB, 0, 0, S_FETCH, C_F0, 4'd0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
